match_ctrl: RTL and testbench

Frame-rate and match sequencer that sits on both sides of the physics engine. It generates the 60 Hz frame pulse that drives the physics `en` input. It consumes the physics `valid`/`game_over`/`winner` outputs to keep score and run the match state machine. It also gates player inputs and frame advance during title, point-pause and match-over phases, and exports score and phase to the HUD renderer.

---
 rtl/match_pkg.sv | 22 ++
 rtl/match_ctrl_frame_divider.sv | 39 +++
 rtl/match_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_match_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/match_pkg.sv
// -----------------------------------------------------------------------------
// match_pkg
// Shared types and constants for the match sequencer. The physics engine and
// the HUD renderer use the same winner encoding.
//   phase_t    : match phase as seen by the HUD (IDLE, PLAY, POINT_PAUSE,
//                MATCH_OVER)
//   WINNER_*   : two-bit player encoding used by physics and the HUD
// -----------------------------------------------------------------------------
package match_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        PLAY        = 2'd1,
        POINT_PAUSE = 2'd2,
        MATCH_OVER  = 2'd3
    } phase_t;

    localparam logic [1:0] WINNER_NONE = 2'd0;
    localparam logic [1:0] WINNER_P1   = 2'd1;
    localparam logic [1:0] WINNER_P2   = 2'd2;

endpackage

// File: rtl/match_ctrl_frame_divider.sv
// -----------------------------------------------------------------------------
// frame_divider
// Free-running clock divider that produces a one-cycle tick once every
// CLK_HZ/FRAME_HZ clocks. The display timing logic reuses it as well.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset (count returns to 0)
//   tick  : high for one cycle when the count reaches its terminal value
// -----------------------------------------------------------------------------
module frame_divider #(
    parameter int CLK_HZ   = 100000000,
    parameter int FRAME_HZ = 60
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int DIV   = CLK_HZ / FRAME_HZ - 1;
    localparam int CNT_W = (DIV > 0) ? $clog2(DIV + 1) : 1;
    localparam logic [CNT_W-1:0] DIV_C = CNT_W'(DIV);

    logic [CNT_W-1:0] r_count;

    // Count 0..DIV and wrap; the tick is decoded from the terminal count so it
    // lines up with the cycle in which the counter wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (r_count == DIV_C) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign tick = (r_count == DIV_C);

endmodule

// File: rtl/match_ctrl.sv
// -----------------------------------------------------------------------------
// match_ctrl
// Frame-rate and match sequencer around the physics engine. It generates the
// frame pulse, gates frame advance and player inputs by match phase, keeps
// score from the physics point reports and exports score/phase to the HUD.
// Optional build macro:
//   DEUCE_EN : a win also needs a two-point lead; once either score has
//              saturated, the next point wins outright.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   start_btn       : debounced start level (rising edge is used)
//   phys_valid      : physics frame-done strobe
//   phys_game_over  : physics point-ended flag
//   phys_winner     : scoring player (1 = P1, 2 = P2, others ignored)
//   frame_tick      : free-running frame pulse for the renderer
//   frame_en        : gated frame pulse driving physics en
//   inputs_en       : player control enable (PLAY only)
//   p1_score/p2_score : registered scores
//   phase           : registered match phase
//   pause_left      : remaining frozen frames of the point pause
//   match_winner    : winner of the match, meaningful in MATCH_OVER
// -----------------------------------------------------------------------------
module match_ctrl
    import match_pkg::*;
#(
    parameter int CLK_HZ       = 100000000,
    parameter int FRAME_HZ     = 60,
    parameter int WIN_SCORE    = 7,
    parameter int PAUSE_FRAMES = 90,
    parameter int SCORE_W      = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_btn,
    input  logic               phys_valid,
    input  logic               phys_game_over,
    input  logic [1:0]         phys_winner,
    output logic               frame_tick,
    output logic               frame_en,
    output logic               inputs_en,
    output logic [SCORE_W-1:0] p1_score,
    output logic [SCORE_W-1:0] p2_score,
    output logic [1:0]         phase,
    output logic [7:0]         pause_left,
    output logic [1:0]         match_winner
);

    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [SCORE_W-1:0] WIN_C     = SCORE_W'(WIN_SCORE);
    localparam logic [7:0]         PAUSE_C   = 8'(PAUSE_FRAMES);

    phase_t             r_phase;
    phase_t             w_nextPhase;
    logic               r_startQ;
    logic [SCORE_W-1:0] r_p1Score;
    logic [SCORE_W-1:0] r_p2Score;
    logic [7:0]         r_pauseLeft;
    logic               r_firstPending;
    logic [1:0]         r_matchWinner;

    logic               w_tick;
    logic               w_startRise;
    logic               w_point;
    logic               w_scorerIsP1;
    logic [SCORE_W-1:0] w_scorerOld;
    logic [SCORE_W-1:0] w_otherScore;
    logic [SCORE_W-1:0] w_scorerNew;
    logic               w_scorerWins;
    logic               w_frameEn;
    logic               w_inputsEn;

    frame_divider #(
        .CLK_HZ   (CLK_HZ),
        .FRAME_HZ (FRAME_HZ)
    ) u_divider (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (w_tick)
    );

    assign w_startRise = start_btn & ~r_startQ;

    // A point only counts while playing and only with a real player id, so a
    // malformed winner code never moves the state machine.
    assign w_point = (r_phase == PLAY) & phys_valid & phys_game_over &
                     ((phys_winner == WINNER_P1) | (phys_winner == WINNER_P2));

    assign w_scorerIsP1 = (phys_winner == WINNER_P1);
    assign w_scorerOld  = w_scorerIsP1 ? r_p1Score : r_p2Score;
    assign w_otherScore = w_scorerIsP1 ? r_p2Score : r_p1Score;
    assign w_scorerNew  = (w_scorerOld == SCORE_MAX) ? SCORE_MAX : w_scorerOld + 1'b1;

`ifdef DEUCE_EN
    // Sudden death once either counter is pinned at its maximum; otherwise
    // the scorer needs both the target score and a two-point lead.
    assign w_scorerWins = (w_scorerOld == SCORE_MAX) || (w_otherScore == SCORE_MAX) ||
                          ((w_scorerNew >= WIN_C) &&
                           ({1'b0, w_scorerNew} >= ({1'b0, w_otherScore} + (SCORE_W+1)'(2))));
`else
    assign w_scorerWins = (w_scorerNew >= WIN_C);
`endif

    // Phase register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= IDLE;
        end else begin
            r_phase <= w_nextPhase;
        end
    end

    // Next-phase logic. The pause ends on the tick that takes pause_left from
    // 1 to 0; the first tick of a pause is reserved for the physics reset frame.
    always_comb begin
        w_nextPhase = r_phase;
        case (r_phase)
            IDLE:        if (w_startRise) w_nextPhase = PLAY;
            PLAY:        if (w_point) w_nextPhase = POINT_PAUSE;
            POINT_PAUSE: begin
                if (w_tick && !r_firstPending && (r_pauseLeft == 8'd1)) begin
                    w_nextPhase = (r_matchWinner != WINNER_NONE) ? MATCH_OVER : PLAY;
                end
            end
            MATCH_OVER:  if (w_startRise) w_nextPhase = PLAY;
            default:     w_nextPhase = IDLE;
        endcase
    end

    // Phase-decoded outputs. During a pause only the first tick reaches
    // physics so it can reposition and clear game_over.
    always_comb begin
        w_frameEn  = 1'b0;
        w_inputsEn = 1'b0;
        case (r_phase)
            PLAY: begin
                w_frameEn  = w_tick;
                w_inputsEn = 1'b1;
            end
            POINT_PAUSE: w_frameEn = w_tick & r_firstPending;
            default: ;
        endcase
    end

    // Score, pause countdown, winner and start-edge history. A new match
    // clears the scores on the same edge that enters PLAY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_startQ       <= 1'b0;
            r_p1Score      <= '0;
            r_p2Score      <= '0;
            r_pauseLeft    <= '0;
            r_firstPending <= 1'b0;
            r_matchWinner  <= WINNER_NONE;
        end else begin
            r_startQ <= start_btn;
            case (r_phase)
                IDLE, MATCH_OVER: begin
                    if (w_startRise) begin
                        r_p1Score     <= '0;
                        r_p2Score     <= '0;
                        r_matchWinner <= WINNER_NONE;
                    end
                end
                PLAY: begin
                    if (w_point) begin
                        if (w_scorerIsP1) begin
                            r_p1Score <= w_scorerNew;
                        end else begin
                            r_p2Score <= w_scorerNew;
                        end
                        r_pauseLeft    <= PAUSE_C;
                        r_firstPending <= 1'b1;
                        r_matchWinner  <= w_scorerWins ? phys_winner : WINNER_NONE;
                    end
                end
                POINT_PAUSE: begin
                    if (w_tick) begin
                        if (r_firstPending) begin
                            r_firstPending <= 1'b0;
                        end else begin
                            r_pauseLeft <= r_pauseLeft - 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign frame_tick   = w_tick;
    assign frame_en     = w_frameEn;
    assign inputs_en    = w_inputsEn;
    assign p1_score     = r_p1Score;
    assign p2_score     = r_p2Score;
    assign phase        = r_phase;
    assign pause_left   = r_pauseLeft;
    assign match_winner = r_matchWinner;

endmodule

// File: tb/tb_match_ctrl.sv
// -----------------------------------------------------------------------------
// tb_match_ctrl
// Self-checking bench for match_ctrl with a 10-cycle frame, a 3-point match
// and a 4-frame point pause. A behavioural model runs alongside the DUT; each
// cycle the expected outputs are queued when inputs are driven and compared
// after the clock edge. Build with DEUCE_EN defined to exercise the deuce rule.
// -----------------------------------------------------------------------------
module tb_match_ctrl;

    localparam int CLK_HZ   = 600;
    localparam int FRAME_HZ = 60;
    localparam int WIN      = 3;
    localparam int PAUSE    = 4;
    localparam int SW       = 4;
    localparam int DIV      = 9;
    localparam int SMAX     = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_btn = 1'b0;
    logic          phys_valid = 1'b0;
    logic          phys_game_over = 1'b0;
    logic [1:0]    phys_winner = 2'd0;
    logic          frame_tick;
    logic          frame_en;
    logic          inputs_en;
    logic [SW-1:0] p1_score;
    logic [SW-1:0] p2_score;
    logic [1:0]    phase;
    logic [7:0]    pause_left;
    logic [1:0]    match_winner;

    typedef struct packed {
        logic          tick;
        logic          en;
        logic          inEn;
        logic [SW-1:0] p1;
        logic [SW-1:0] p2;
        logic [1:0]    ph;
        logic [7:0]    pl;
        logic [1:0]    win;
    } exp_t;

    exp_t sbQ[$];

    int checks = 0;
    int errors = 0;
    int pauseTicks = 0;
    int pauseEns = 0;

    int mPhase, mP1, mP2, mPause, mFirst, mWin, mDiv, mStartQ;

    match_ctrl #(
        .CLK_HZ       (CLK_HZ),
        .FRAME_HZ     (FRAME_HZ),
        .WIN_SCORE    (WIN),
        .PAUSE_FRAMES (PAUSE),
        .SCORE_W      (SW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_btn      (start_btn),
        .phys_valid     (phys_valid),
        .phys_game_over (phys_game_over),
        .phys_winner    (phys_winner),
        .frame_tick     (frame_tick),
        .frame_en       (frame_en),
        .inputs_en      (inputs_en),
        .p1_score       (p1_score),
        .p2_score       (p2_score),
        .phase          (phase),
        .pause_left     (pause_left),
        .match_winner   (match_winner)
    );

    always #5 clk = ~clk;

    // Hard time limit so a stuck DUT can never hang the run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic resetModel();
        mPhase = 0; mP1 = 0; mP2 = 0; mPause = 0;
        mFirst = 0; mWin = 0; mDiv = 0; mStartQ = 0;
    endtask

    // Winner rule from the scorer's viewpoint, using old and new scores.
    function automatic bit modelWins(input int mineOld, input int mine, input int other);
`ifdef DEUCE_EN
        if (mineOld == SMAX || other == SMAX) return 1'b1;
        return (mine >= WIN) && (mine - other >= 2);
`else
        return (mine >= WIN);
`endif
    endfunction

    // Advance the model by one clock edge given the inputs of that cycle.
    task automatic modelStep(input logic s, input logic v, input logic g, input logic [1:0] w);
        bit tick;
        bit rise;
        int mineOld, mine, other;
        tick = (mDiv == DIV);
        rise = s && (mStartQ == 0);
        mStartQ = s;
        mDiv = tick ? 0 : mDiv + 1;
        case (mPhase)
            0, 3: begin
                if (rise) begin
                    mPhase = 1; mP1 = 0; mP2 = 0; mWin = 0;
                end
            end
            1: begin
                if (v && g && (w == 2'd1 || w == 2'd2)) begin
                    mineOld = (w == 2'd1) ? mP1 : mP2;
                    other   = (w == 2'd1) ? mP2 : mP1;
                    mine    = (mineOld == SMAX) ? SMAX : mineOld + 1;
                    if (w == 2'd1) mP1 = mine; else mP2 = mine;
                    mWin   = modelWins(mineOld, mine, other) ? int'(w) : 0;
                    mPause = PAUSE;
                    mFirst = 1;
                    mPhase = 2;
                end
            end
            default: begin
                if (tick) begin
                    if (mFirst != 0) begin
                        mFirst = 0;
                    end else begin
                        if (mPause == 1) mPhase = (mWin != 0) ? 3 : 1;
                        mPause = mPause - 1;
                    end
                end
            end
        endcase
    endtask

    function automatic exp_t modelOutputs();
        exp_t e;
        e.tick = (mDiv == DIV);
        e.en   = (mPhase == 1) ? e.tick : ((mPhase == 2) ? (e.tick && mFirst != 0) : 1'b0);
        e.inEn = (mPhase == 1);
        e.p1   = SW'(mP1);
        e.p2   = SW'(mP2);
        e.ph   = 2'(mPhase);
        e.pl   = 8'(mPause);
        e.win  = 2'(mWin);
        return e;
    endfunction

    task automatic applyStimulus(input logic s, input logic v, input logic g, input logic [1:0] w);
        start_btn      = s;
        phys_valid     = v;
        phys_game_over = g;
        phys_winner    = w;
        modelStep(s, v, g, w);
        sbQ.push_back(modelOutputs());
    endtask

    task automatic compareScoreboard();
        exp_t e;
        if (sbQ.size() == 0) begin
            checkOutput("sbEmpty", 32'd0, 32'd1);
            return;
        end
        e = sbQ.pop_front();
        checkOutput("frame_tick", frame_tick, e.tick);
        checkOutput("frame_en", frame_en, e.en);
        checkOutput("inputs_en", inputs_en, e.inEn);
        checkOutput("p1_score", p1_score, e.p1);
        checkOutput("p2_score", p2_score, e.p2);
        checkOutput("phase", phase, e.ph);
        checkOutput("pause_left", pause_left, e.pl);
        checkOutput("match_winner", match_winner, e.win);
        if (phase == 2'd2) begin
            pauseTicks += int'(frame_tick);
            pauseEns   += int'(frame_en);
        end
    endtask

    task automatic runCycle(input logic s, input logic v, input logic g, input logic [1:0] w);
        applyStimulus(s, v, g, w);
        @(posedge clk);
        #1;
        compareScoreboard();
    endtask

    task automatic idleCycles(input int n);
        repeat (n) runCycle(1'b0, 1'b0, 1'b0, 2'd0);
    endtask

    task automatic waitPhase(input int target, input string tag);
        int n = 0;
        while (phase !== 2'(target) && n < 200) begin
            runCycle(1'b0, 1'b0, 1'b0, 2'd0);
            n++;
        end
        checkOutput(tag, phase, target);
    endtask

    task automatic scorePoint(input logic [1:0] who, input int target);
        runCycle(1'b0, 1'b1, 1'b1, who);
        waitPhase(target, "pauseExit");
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_phase"}, phase, 0);
        checkOutput({tag, "_p1"}, p1_score, 0);
        checkOutput({tag, "_p2"}, p2_score, 0);
        checkOutput({tag, "_pause"}, pause_left, 0);
        checkOutput({tag, "_win"}, match_winner, 0);
        checkOutput({tag, "_tick"}, frame_tick, 0);
        checkOutput({tag, "_en"}, frame_en, 0);
        checkOutput({tag, "_inEn"}, inputs_en, 0);
    endtask

    initial begin
        int firstTick;
        int tickCount;
        int enCount;
        int trans;
        logic [1:0] prevPhase;
        int n;

        $display("[TB] match_ctrl bench start");
        resetModel();
        repeat (3) @(posedge clk);
        #1;
        checkAllZero("reset");
        rst_n = 1'b1;

        // Idle free-run: ticks every 10 cycles, first after 9 edges, no frame_en.
        firstTick = -1; tickCount = 0; enCount = 0;
        for (int k = 0; k < 30; k++) begin
            runCycle(1'b0, 1'b0, 1'b0, 2'd0);
            if (frame_tick === 1'b1 && firstTick < 0) firstTick = k + 1;
            tickCount += int'(frame_tick);
            enCount   += int'(frame_en);
        end
        checkOutput("firstTick", firstTick, 9);
        checkOutput("idleTicks", tickCount, 3);
        checkOutput("idleFrameEn", enCount, 0);

        // Held start level gives exactly one IDLE->PLAY transition.
        trans = 0;
        prevPhase = phase;
        for (int k = 0; k < 50; k++) begin
            runCycle(1'b1, 1'b0, 1'b0, 2'd0);
            if (phase !== prevPhase) trans++;
            prevPhase = phase;
        end
        checkOutput("startTrans", trans, 1);
        checkOutput("playPhase", phase, 1);
        checkOutput("playInputsEn", inputs_en, 1);
        idleCycles(5);

        // Single P1 point and the full pause sequence.
        pauseTicks = 0; pauseEns = 0;
        runCycle(1'b0, 1'b1, 1'b1, 2'd1);
        checkOutput("ptP1Score", p1_score, 1);
        checkOutput("ptPhase", phase, 2);
        checkOutput("ptPauseLeft", pause_left, 4);
        waitPhase(1, "pauseToPlay");
        checkOutput("pauseFrameEns", pauseEns, 1);
        checkOutput("pauseTicks", pauseTicks, 5);
        checkOutput("pauseDone", pause_left, 0);

        // Three P2 points win the match, then restart.
        scorePoint(2'd2, 1);
        scorePoint(2'd2, 1);
        scorePoint(2'd2, 3);
        checkOutput("overP2", p2_score, 3);
        checkOutput("overP1", p1_score, 1);
        checkOutput("overWinner", match_winner, 2);
        idleCycles(3);
        checkOutput("overHeldP2", p2_score, 3);
        runCycle(1'b1, 1'b0, 1'b0, 2'd0);
        checkOutput("restartPhase", phase, 1);
        checkOutput("restartP1", p1_score, 0);
        checkOutput("restartP2", p2_score, 0);
        checkOutput("restartWin", match_winner, 0);
        runCycle(1'b1, 1'b0, 1'b0, 2'd0);
        idleCycles(2);

        // Invalid winner codes and non-point strobes are ignored.
        runCycle(1'b0, 1'b1, 1'b1, 2'd0);
        runCycle(1'b0, 1'b1, 1'b1, 2'd3);
        runCycle(1'b0, 1'b1, 1'b0, 2'd1);
        runCycle(1'b0, 1'b0, 1'b1, 2'd2);
        checkOutput("badWinPhase", phase, 1);
        checkOutput("badWinP1", p1_score, 0);
        checkOutput("badWinP2", p2_score, 0);
        runCycle(1'b0, 1'b1, 1'b1, 2'd1);
        runCycle(1'b0, 1'b1, 1'b1, 2'd2);
        checkOutput("pauseIgnP2", p2_score, 0);
        checkOutput("pauseIgnP1", p1_score, 1);
        checkOutput("pauseIgnPhase", phase, 2);

        // Asynchronous reset in the middle of the pause.
        n = 0;
        while (pause_left !== 8'd2 && n < 200) begin
            runCycle(1'b0, 1'b0, 1'b0, 2'd0);
            n++;
        end
        checkOutput("reachPause2", pause_left, 2);
        #3;
        rst_n = 1'b0;
        #1;
        checkAllZero("midReset");
        resetModel();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idleCycles(25);

`ifdef DEUCE_EN
        runCycle(1'b1, 1'b0, 1'b0, 2'd0);
        idleCycles(1);
        scorePoint(2'd1, 1);
        scorePoint(2'd2, 1);
        scorePoint(2'd1, 1);
        scorePoint(2'd2, 1);
        scorePoint(2'd1, 1);
        scorePoint(2'd2, 1);
        checkOutput("deuceP1", p1_score, 3);
        checkOutput("deuceP2", p2_score, 3);
        scorePoint(2'd1, 1);
        checkOutput("advP1", p1_score, 4);
        checkOutput("advWin", match_winner, 0);
        scorePoint(2'd1, 3);
        checkOutput("deuceWinP1", p1_score, 5);
        checkOutput("deuceWinner", match_winner, 1);
`else
        runCycle(1'b1, 1'b0, 1'b0, 2'd0);
        idleCycles(1);
        scorePoint(2'd1, 1);
        scorePoint(2'd1, 1);
        scorePoint(2'd1, 3);
        checkOutput("p1WinScore", p1_score, 3);
        checkOutput("p1Winner", match_winner, 1);
`endif
        idleCycles(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
